hazard_scoreboard: RTL and testbench

Parametrised pipeline hazard controller that sits between the IF/ID and ID/EX buffers. It tracks in-flight register writes in a per-register countdown scoreboard and stalls dependent instructions in ID until their operands reach the forwarding path. It also flushes the front end for a configurable number of cycles after a taken branch and enters a sticky halt on the halt opcode. It exports a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 tb/tb_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: per-register countdown scoreboard for load/ALU
// latency stalls, branch flush sequencing, sticky halt and a stall-cycle counter.
module hazard_scoreboard #(
  parameter int NREGS    = 16,
  parameter int REG_W    = 4,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic             id_halt,
  input  logic             ex_branch_taken,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MAX_LAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int CW      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam int FW      = (BR_FLUSH > 1) ? $clog2(BR_FLUSH) : 1;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  state_t            state;
  logic [FW-1:0]     fl_cnt;
  logic [CW-1:0]     cnt [NREGS];
  logic [CNT_W-1:0]  stall_cnt;

  // Padded to the full index space so out-of-range indices read as idle.
  logic [2**REG_W-1:0] busy;
  logic                haz;
  logic                issue;
  logic                stall;
  logic                flushing;
  logic                halt_out;

  always_comb begin
    busy = '0;
    for (int unsigned r = 0; r < NREGS; r++)
      busy[r] = (cnt[r] != '0);
  end

  always_comb begin
    haz      = id_valid & ((id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2]));
    issue    = id_valid & ~haz & (state == S_RUN) & ~ex_branch_taken & ~reset;
    stall    = ~reset & (state == S_RUN) & ~ex_branch_taken & haz;
    flushing = ~reset & ((state == S_FLUSH) | (ex_branch_taken & (state != S_HALT)));
    halt_out = ~reset & (state == S_HALT);
  end

  always_comb begin
    pc_hold      = stall | halt_out;
    if_id_hold   = stall | halt_out;
    if_id_flush  = flushing;
    id_ex_bubble = stall | flushing | halt_out;
    halted       = halt_out;
    stall_cycles = reset ? '0 : stall_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++)
        cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (issue && id_wr && (id_rd == REG_W'(r)))
          cnt[r] <= id_is_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  // A taken branch outranks a same-cycle halt: the halt is on the wrong path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_RUN;
      fl_cnt <= '0;
    end else if (ex_branch_taken && (state != S_HALT)) begin
      state  <= S_FLUSH;
      fl_cnt <= FW'(BR_FLUSH - 1);
    end else begin
      case (state)
        S_FLUSH: begin
          if (fl_cnt == '0)
            state <= S_RUN;
          else
            fl_cnt <= fl_cnt - 1'b1;
        end
        S_RUN: begin
          if (issue && id_halt)
            state <= S_HALT;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: two instances with different latency,
// flush length, counter width and register count share one stimulus stream.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_wr, id_is_load, id_halt;
  logic       ex_branch_taken;

  logic        pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_bubble_a, halted_a;
  logic [15:0] stall_cycles_a;
  logic        pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_bubble_b, halted_b;
  logic [2:0]  stall_cycles_b;

  logic [4:0] outs_a, outs_b;
  assign outs_a = {pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_bubble_a, halted_a};
  assign outs_b = {pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_bubble_b, halted_b};

  // {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, halted}
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_STALL = 5'b11010;
  localparam logic [4:0] O_FLUSH = 5'b00110;
  localparam logic [4:0] O_HALT  = 5'b11011;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREGS(16), .REG_W(4), .ALU_LAT(0), .LOAD_LAT(1), .BR_FLUSH(2), .CNT_W(16)
  ) u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load), .id_halt(id_halt),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold_a), .if_id_hold(if_id_hold_a), .if_id_flush(if_id_flush_a),
    .id_ex_bubble(id_ex_bubble_a), .halted(halted_a), .stall_cycles(stall_cycles_a)
  );

  hazard_scoreboard #(
    .NREGS(12), .REG_W(4), .ALU_LAT(0), .LOAD_LAT(3), .BR_FLUSH(1), .CNT_W(3)
  ) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load), .id_halt(id_halt),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold_b), .if_id_hold(if_id_hold_b), .if_id_flush(if_id_flush_b),
    .id_ex_bubble(id_ex_bubble_b), .halted(halted_b), .stall_cycles(stall_cycles_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                       input logic wr, input logic ld, input logic hlt, input logic br);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_wr = wr; id_is_load = ld; id_halt = hlt; ex_branch_taken = br;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset cycle with every input trying to provoke an output.
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("rst_a", outs_a, O_IDLE);
    check("rst_b", outs_b, O_IDLE);
    check("rst_cnt_a", stall_cycles_a, 0);
    tick();
    reset = 1'b0;

    // Load-use on u_a (LOAD_LAT=1): one bubble.
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    check("lu_load", outs_a, O_IDLE);
    tick();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    check("lu_stall", outs_a, O_STALL);
    tick();
    check("lu_issue", outs_a, O_IDLE);
    check("lu_cnt", stall_cycles_a, 1);
    tick();

    // ALU back-to-back and unused source.
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    check("alu_b2b", outs_a, O_IDLE);
    tick();
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(1, 2, 0, 0, 0, 6, 1, 0, 0, 0);
    check("unused_src", outs_a, O_IDLE);
    check("unused_cnt", stall_cycles_a, 1);
    tick();

    // Branch while ID holds a hazard (BR_FLUSH=2).
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    tick();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 1);
    check("br_cyc", outs_a, O_FLUSH);
    tick();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    check("br_fl1", outs_a, O_FLUSH);
    tick();
    check("br_fl2", outs_a, O_FLUSH);
    tick();
    check("br_run", outs_a, O_IDLE);
    check("br_cnt", stall_cycles_a, 1);
    tick();

    // Halt coinciding with a taken branch: no HALT.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("hb_cyc", outs_a, O_FLUSH);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("hb_fl1", outs_a, O_FLUSH);
    tick();
    check("hb_fl2", outs_a, O_FLUSH);
    tick();
    check("hb_run", outs_a, O_IDLE);
    tick();

    // Halt issues, then sticks for 100 cycles even across a branch.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("halt_issue", outs_a, O_IDLE);
    tick();
    for (int i = 0; i < 100; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 50));
      check("halt_hold", outs_a, O_HALT);
      tick();
    end

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst2_a", outs_a, O_IDLE);
    check("rst2_b", outs_b, O_IDLE);
    tick();
    reset = 1'b0;

    // Reset in the second stall cycle of a LOAD_LAT=3 load-use on u_b.
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    tick();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    check("b_stall1", outs_b, O_STALL);
    tick();
    check("b_stall2", outs_b, O_STALL);
    reset = 1'b1;
    #1;
    check("b_rst_cyc", outs_b, O_IDLE);
    check("b_rst_cnt", stall_cycles_b, 0);
    tick();
    reset = 1'b0;
    #1;
    check("b_after_rst", outs_b, O_IDLE);
    check("b_after_cnt", stall_cycles_b, 0);
    tick();

    // Self-dependent load held in ID: issue, 3 stalls, repeat (u_b saturates at 7).
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, 0, 0, 1, 1, 1, 0, 0);
      if (i == 1) check("sat_stall", outs_b, O_STALL);
      if (i == 4) check("sat_reissue", outs_b, O_IDLE);
      tick();
    end
    check("sat_b", stall_cycles_b, 7);
    check("count_a", stall_cycles_a, 10);
    for (int i = 0; i < 8; i++) tick();
    check("sat_hold_b", stall_cycles_b, 7);
    check("count_a2", stall_cycles_a, 14);

    // Index 13 is beyond u_b's 12 registers but valid for u_a.
    drive(1, 0, 0, 0, 0, 13, 1, 1, 0, 0);
    tick();
    drive(1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    check("oor_b", outs_b, O_IDLE);
    check("oor_a", outs_a, O_STALL);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
